// File: rtl/ram_mem_pkg.sv
// Shared definitions for the RMW RAM wrapper: controller state encoding,
// byte-lane width constants and the per-byte merge used on partial writes.
package ram_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } rmw_state_t;

    localparam int BYTE_W      = 8;
    localparam int BYTE_W_LOG2 = 3;

    // Number of byte-address bits below the word index for a given word width.
    function automatic int byte_shift(input int data_w);
        return $clog2(data_w >> BYTE_W_LOG2);
    endfunction

    function automatic logic [BYTE_W-1:0] merge_byte(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, registered read, write-first.
// Latency: 1 cycle read; no backpressure, enable freezes both array and output register.
// Backpressure: none; caller gates with enable.
module ram_array #(
    parameter  int DATA_W      = 64,
    parameter  int DEPTH_WORDS = 32768,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              enable,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (enable) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_memory_rmw.sv
// Byte-addressed word RAM; sub-word writes become an internal read-modify-write.
// Latency: reads, full/empty writes and range errors respond 1 cycle after acceptance, partial writes 3.
// Backpressure: req_ready low during the 2 RMW cycles and while clock_enable is low; responses never stall.
module ram_memory_rmw
    import ram_mem_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 36,
    parameter int                DEPTH_WORDS = 32768,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clock_enable,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/BYTE_W-1:0]   req_be,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int SHIFT = byte_shift(DATA_W);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W = ADDR_W - SHIFT;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
        logic [NB-1:0]     be;
    } rmw_req_t;

    rmw_state_t        state, state_nxt;
    rmw_req_t          rmw_q;

    logic [ADDR_W-1:0] addr_off;
    logic [OFF_W-1:0]  word_off;
    logic [IDX_W-1:0]  req_idx;
    logic              out_of_range;
    logic              be_full, be_none;
    logic              accept, start_rmw, one_shot;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata, merged;

    logic              pend_vld, pend_err, pend_rd;

    // Address decode: any offset bit above the index width means out of range.
    assign addr_off     = req_addr - BASE_ADDR;
    assign word_off     = OFF_W'(addr_off >> SHIFT);
    assign req_idx      = word_off[IDX_W-1:0];
    assign out_of_range = (req_addr < BASE_ADDR) || ((word_off >> IDX_W) != '0);

    assign be_full = &req_be;
    assign be_none = ~|req_be;

    assign req_ready = (state == IDLE) && clock_enable && reset_n;
    assign accept    = req_valid && req_ready;
    assign start_rmw = accept && req_write && !out_of_range && !be_full && !be_none;
    assign one_shot  = accept && !start_rmw;

    always_comb begin
        merged = '0;
        for (int b = 0; b < NB; b++) begin
            merged[BYTE_W*b +: BYTE_W] = merge_byte(ram_rdata[BYTE_W*b +: BYTE_W],
                                                    rmw_q.wdata[BYTE_W*b +: BYTE_W],
                                                    rmw_q.be[b]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (clock_enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = req_idx;
        ram_wdata = req_wdata;
        unique case (state)
            IDLE: begin
                ram_we = accept && req_write && !out_of_range && be_full;
                if (start_rmw) begin
                    state_nxt = RMW_RD;
                end
            end
            RMW_RD: begin
                ram_addr  = rmw_q.idx;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                ram_addr  = rmw_q.idx;
                ram_wdata = merged;
                ram_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One pending stage so every response leaves one edge after its completing edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rmw_q     <= '0;
            pend_vld  <= 1'b0;
            pend_err  <= 1'b0;
            pend_rd   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (clock_enable) begin
            if (start_rmw) begin
                rmw_q <= '{idx: req_idx, wdata: req_wdata, be: req_be};
            end
            pend_vld  <= one_shot || (state == RMW_WR);
            pend_err  <= accept && out_of_range;
            pend_rd   <= accept && !req_write && !out_of_range;
            rsp_valid <= pend_vld;
            rsp_err   <= pend_vld && pend_err;
            rsp_rdata <= (pend_vld && pend_rd) ? ram_rdata : '0;
        end
    end

    ram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock  (clock),
        .enable (clock_enable),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_ram_memory_rmw.sv
// Directed plus random checks of ram_memory_rmw against a byte-level word model.
module tb_ram_memory_rmw;

    localparam int ADDR_W = 36;
    localparam int DEPTH  = 32768;
    localparam int NB     = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              clock_enable = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic [NB-1:0]     req_be = '0;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;

    int total = 0;
    int bad   = 0;
    logic [63:0] model [int];

    ram_memory_rmw dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'd8 * 64'(DEPTH);
    endfunction

    function automatic int word_of(input logic [ADDR_W-1:0] a);
        return int'(64'(a) / 64'd8);
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [63:0] d,
                                        input logic [NB-1:0] be);
        logic [63:0] w;
        w = model.exists(word_of(a)) ? model[word_of(a)] : 64'd0;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model[word_of(a)] = w;
    endfunction

    // Starts at a negedge in IDLE; returns at a negedge after the response has dropped.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [63:0] d,
                         input logic [NB-1:0] be, output logic [63:0] rd, output logic er,
                         output int lat, output int rlow);
        check("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = -1; rlow = 0; rd = '0; er = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat = j; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (!req_ready) rlow++;
        end
        if (lat >= 0) begin
            @(negedge clock);
            check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [63:0] d, input logic [NB-1:0] be);
        logic [63:0] rd, exp_rd;
        logic        er;
        int          lat, rlow;
        bit          inr, partial;
        inr     = in_range(a);
        partial = w && inr && (be != 8'h00) && (be != 8'hFF);
        exp_rd  = (!w && inr) ? model[word_of(a)] : 64'd0;
        issue(w, a, d, be, rd, er, lat, rlow);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 64'(er), 64'(!inr));
        check({tag, "_lat"}, 64'(lat), partial ? 64'd3 : 64'd1);
        check({tag, "_busy"}, 64'(rlow), partial ? 64'd2 : 64'd0);
        if (w && inr) model_write(a, d, be);
    endtask

    initial begin
        logic [63:0]       rd_t, d_a, d_b, exp_v;
        logic              er_t, wr;
        int                lat_t, rl_t, sel;
        bit                saw;
        logic [ADDR_W-1:0] a;
        logic [63:0]       d;
        logic [NB-1:0]     be;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 64'(req_ready), 64'd1);

        // Full write then read
        run_op("wr10", 1'b1, 36'h10, 64'h1122334455667788, 8'hFF);
        run_op("rd10", 1'b0, 36'h10, 64'd0, 8'h00);

        // Partial write merge
        run_op("pw10", 1'b1, 36'h10, 64'hFFFFFFFFAAAAAAAA, 8'h0F);
        issue(1'b0, 36'h10, 64'd0, 8'h00, rd_t, er_t, lat_t, rl_t);
        check("pw10_merged", rd_t, 64'h11223344AAAAAAAA);

        // Range boundary
        run_op("oor_rd", 1'b0, 36'h40000, 64'd0, 8'h00);
        run_op("oor_wr", 1'b1, 36'h40010, 64'hDEADBEEFDEADBEEF, 8'hFF);
        run_op("oor_hi", 1'b1, 36'hF_FFFF_FFF8, 64'h0123456789ABCDEF, 8'h3C);
        run_op("rd10_after_oor", 1'b0, 36'h10, 64'd0, 8'h00);
        run_op("wr_last", 1'b1, 36'h3FFF8, 64'hCAFEF00D12345678, 8'hFF);
        run_op("rd_last", 1'b0, 36'h3FFF8, 64'd0, 8'h00);
        run_op("noop_wr", 1'b1, 36'h10, 64'h5555555555555555, 8'h00);
        run_op("rd10_noop", 1'b0, 36'h10, 64'd0, 8'h00);

        // Reset pulsed while in RMW_WR must abort the merge
        req_valid = 1'b1; req_write = 1'b1; req_addr = 36'h10;
        req_wdata = 64'h0BADC0DE0BADC0DE; req_be = 8'hF0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("abort_in_rd_busy", 64'(req_ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_rst_ready", 64'(req_ready), 64'd0);
        check("abort_rst_valid", 64'(rsp_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            if (rsp_valid) saw = 1'b1;
        end
        check("abort_no_rsp", 64'(saw), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        run_op("abort_readback", 1'b0, 36'h10, 64'd0, 8'h00);

        // clock_enable low for 5 cycles inside an RMW
        d = {$urandom, $urandom};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 36'h10; req_wdata = d; req_be = 8'h3C;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        clock_enable = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("ce_frozen_valid", 64'(rsp_valid), 64'd0);
        clock_enable = 1'b1;
        #1 check("ce_frozen_busy", 64'(req_ready), 64'd0);
        lat_t = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat_t = 5 + j;
                break;
            end
        end
        check("ce_total_lat", 64'(lat_t), 64'd8);
        model_write(36'h10, d, 8'h3C);

        // Outputs hold while disabled with a response showing
        exp_v = model[2];
        req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h10;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("frz_valid", 64'(rsp_valid), 64'd1);
        check("frz_rdata", rsp_rdata, exp_v);
        clock_enable = 1'b0;
        repeat (3) @(negedge clock);
        check("frz_hold_valid", 64'(rsp_valid), 64'd1);
        check("frz_hold_rdata", rsp_rdata, exp_v);
        clock_enable = 1'b1;
        @(negedge clock);
        check("frz_release", 64'(rsp_valid), 64'd0);

        // Back-to-back: W0, W8, R8 (read right after write), R0
        d_a = {$urandom, $urandom};
        d_b = {$urandom, $urandom};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 36'h0; req_wdata = d_a; req_be = 8'hFF;
        @(posedge clock);
        #1 req_addr = 36'h8; req_wdata = d_b;
        @(negedge clock);
        check("b2b_gap", 64'(rsp_valid), 64'd0);
        @(posedge clock);
        #1 req_write = 1'b0;
        @(negedge clock);
        check("b2b_w0_valid", 64'(rsp_valid), 64'd1);
        check("b2b_w0_err", 64'(rsp_err), 64'd0);
        @(posedge clock);
        #1 req_addr = 36'h0;
        @(negedge clock);
        check("b2b_w8_valid", 64'(rsp_valid), 64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("b2b_r8_valid", 64'(rsp_valid), 64'd1);
        check("b2b_r8_rdata", rsp_rdata, d_b);
        @(negedge clock);
        check("b2b_r0_valid", 64'(rsp_valid), 64'd1);
        check("b2b_r0_rdata", rsp_rdata, d_a);
        @(negedge clock);
        check("b2b_end", 64'(rsp_valid), 64'd0);
        model_write(36'h0, d_a, 8'hFF);
        model_write(36'h8, d_b, 8'hFF);

        // Random traffic over 16 words plus out-of-range addresses
        for (int i = 0; i < 16; i++) begin
            run_op("init", 1'b1, 36'(i * 8), {$urandom, $urandom}, 8'hFF);
        end
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 36'(8 * DEPTH) + 36'($urandom_range(0, 4095));
            else if (sel == 1) a = 36'hF_FFFF_FFF8;
            else               a = 36'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      be = 8'h00;
            else if (sel == 1) be = 8'hFF;
            else               be = 8'($urandom);
            run_op("rnd", wr, a, d, be);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
